// File: rtl/seg7_pkg.sv
// Purpose : shared types and constants for the 7-segment scan driver.
// Latency : n/a (package only).
// Contents: SEG_OFF, 16-entry active-low hex glyph table, FSM state enum, seg7_decode().
package seg7_pkg;

  // All segments dark ({g,f,e,d,c,b,a}, active low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low hex glyphs, indexed by nibble value (entry 15 is listed first).
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    return GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Purpose : slot timer, counts 0..TICKS-1 and strobes the end of the blanking gap and of the slot.
// Latency : strobes are combinational from the count register; i_clear takes effect on the next edge.
// Ports   : clk, rst (async, active high), i_clear (hold count at 0), o_blank_end, o_slot_end.
module seg7_prescaler #(
  parameter int TICKS        = 10,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_blank_end,
  output logic o_slot_end
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_blank_end = (r_cnt == BLANK_LAST);
  assign o_slot_end  = (r_cnt == CNT_LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose : time-multiplexed N-digit 7-segment driver with per-slot blanking gap and tear-free frame updates.
// Latency : seg/an registered, one cycle behind the FSM state; frame_done is decoded from state in the same cycle.
// Ports   : clk, rst, enable, value[4N], load in; seg[7], an[N], digit_idx, frame_done out. No backpressure.
// Option  : SEG7_LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 is always shown).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int CLK_HZ        = 50000000,
  parameter int SLOT_HZ       = 1000,
  parameter int BLANK_CYCLES  = 2,
  parameter int AN_ACTIVE_LOW = 1,
  localparam int DW           = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic [DW-1:0]         digit_idx,
  output logic                  frame_done
);

  localparam int TICKS = CLK_HZ / SLOT_HZ;
  localparam logic [DW-1:0] LAST_DIGIT = DW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  if (TICKS < 4) begin : g_bad_ticks
    $error("seg7_scan_driver: CLK_HZ/SLOT_HZ must be at least 4");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= TICKS) begin : g_bad_blank
    $error("seg7_scan_driver: BLANK_CYCLES must be in 1..TICKS-1");
  end
  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_driver: N_DIGITS must be in 1..8");
  end

  state_t                r_state, w_state_nxt;
  logic [DW-1:0]         r_digit, w_digit_nxt;
  logic [4*N_DIGITS-1:0] r_pending, r_display;
  logic [6:0]            r_seg, w_seg_nxt;
  logic [N_DIGITS-1:0]   r_an, w_an_nxt;

  logic                  w_clear, w_blank_end, w_slot_end, w_frame_end;
  logic [3:0]            w_nibble;
  logic [N_DIGITS-1:0]   w_onehot;
  logic                  w_digit_blank;

  // Counter sits at 0 whenever we are idle so every scan starts on a clean slot.
  assign w_clear = !enable || (r_state == IDLE);

  seg7_prescaler #(
    .TICKS        (TICKS),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .o_blank_end (w_blank_end),
    .o_slot_end  (w_slot_end)
  );

  // Last cycle of the last digit's DRIVE; the display copy happens on the edge that ends it.
  assign w_frame_end = enable && (r_state == DRIVE) && w_slot_end && (r_digit == LAST_DIGIT);

  always_comb begin
    w_nibble = '0;
    w_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_digit == DW'(i)) begin
        w_nibble    = r_display[4*i +: 4];
        w_onehot[i] = 1'b1;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] w_lz_blank;
  logic                w_run_zero;

  // Walk from the most significant digit down; a digit is blanked while every
  // nibble from it upward is zero. Digit 0 is exempt so a zero value shows "0".
  always_comb begin
    w_lz_blank = '0;
    w_run_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_run_zero = w_run_zero && (r_display[4*i +: 4] == 4'h0);
      if (i != 0) begin
        w_lz_blank[i] = w_run_zero;
      end
    end
  end

  assign w_digit_blank = |(w_lz_blank & w_onehot);
`else
  assign w_digit_blank = 1'b0;
`endif

  // Next-state logic. Dropping enable aborts the slot from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_digit_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = BLANK;
          w_digit_nxt = '0;
        end
        BLANK: begin
          if (w_blank_end) begin
            w_state_nxt = DRIVE;
          end
        end
        DRIVE: begin
          if (w_slot_end) begin
            w_state_nxt = BLANK;
            w_digit_nxt = (r_digit == LAST_DIGIT) ? '0 : r_digit + DW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_digit_nxt = '0;
        end
      endcase
    end
  end

  // Output register inputs. BLANK pre-loads the glyph with anodes dark so the
  // segment bus has settled before the anode switches on.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_an_nxt  = AN_OFF;
    if (enable) begin
      case (r_state)
        BLANK: begin
          w_seg_nxt = seg7_decode(w_nibble);
        end
        DRIVE: begin
          w_seg_nxt = w_digit_blank ? SEG_OFF : seg7_decode(w_nibble);
          w_an_nxt  = (AN_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
        end
        default: begin
          w_seg_nxt = SEG_OFF;
          w_an_nxt  = AN_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_digit   <= '0;
      r_pending <= '0;
      r_display <= '0;
      r_seg     <= SEG_OFF;
      r_an      <= AN_OFF;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      if (load) begin
        r_pending <= value;
      end
      // Reads the pre-edge pending, so a load on the boundary lands next frame.
      if (w_frame_end) begin
        r_display <= r_pending;
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign digit_idx  = r_digit;
  assign frame_done = w_frame_end;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose : self-checking bench for seg7_scan_driver (TICKS=10, BLANK_CYCLES=2, 4 digits, active-low anodes).
// Latency : reference model predicts outputs from cycles elapsed since enable and frame-level display values.
// Ports   : drives clk, rst, enable, value, load; observes seg, an, digit_idx, frame_done.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int TICKS = 10;
  localparam int BLK   = 2;
  localparam int FRAME = N * TICKS;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks;
  int errors;

  // Reference model state.
  int          n;          // clock edges since the scan was (re)started, 0 when idle
  logic [15:0] m_pending;
  logic [15:0] m_display;
  logic [6:0]  glyph_tb [16];

  seg7_scan_driver #(
    .N_DIGITS      (N),
    .CLK_HZ        (1000),
    .SLOT_HZ       (100),
    .BLANK_CYCLES  (BLK),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .value      (value),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus followed by a full comparison against the model at the falling edge.
  task automatic step(input logic en, input logic ld, input logic [15:0] val);
    logic [15:0] disp_prev;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic [1:0]  exp_idx;
    logic        exp_fd;
    int          m;
    int          phase;
    int          d;
    enable = en;
    load   = ld;
    value  = val;
    @(posedge clk);
    disp_prev = m_display;
    if (!en) begin
      n = 0;
    end else begin
      n++;
      if (n > 1 && (n - 1) % FRAME == 0) m_display = m_pending;
    end
    if (ld) m_pending = val;
    @(negedge clk);

    exp_seg = 7'h7F;
    exp_an  = 4'hF;
    exp_idx = 2'd0;
    exp_fd  = 1'b0;
    if (n >= 1) begin
      exp_idx = 2'((((n - 1) / TICKS) % N));
      exp_fd  = ((n - 1) % FRAME) == FRAME - 1;
    end
    if (n >= 2) begin
      m       = n - 2;
      phase   = m % TICKS;
      d       = (m / TICKS) % N;
      exp_seg = glyph_tb[(disp_prev >> (4 * d)) & 16'hF];
      if (phase >= BLK) begin
        exp_an = ~(4'b0001 << d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d > 0 && (disp_prev >> (4 * d)) == 16'h0) exp_seg = 7'h7F;
`endif
      end
    end

    checks++;
    if (seg !== exp_seg) begin
      errors++;
      $display("FAIL seg t=%0t n=%0d got %b expected %b", $time, n, seg, exp_seg);
    end
    checks++;
    if (an !== exp_an) begin
      errors++;
      $display("FAIL an t=%0t n=%0d got %b expected %b", $time, n, an, exp_an);
    end
    checks++;
    if (digit_idx !== exp_idx) begin
      errors++;
      $display("FAIL digit_idx t=%0t n=%0d got %0d expected %0d", $time, n, digit_idx, exp_idx);
    end
    checks++;
    if (frame_done !== exp_fd) begin
      errors++;
      $display("FAIL frame_done t=%0t n=%0d got %b expected %b", $time, n, frame_done, exp_fd);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b0;
    load   = 1'b0;
    value  = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h expected 7f", seg); end
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %b expected 1111", an); end
    checks++;
    if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d expected 0", digit_idx); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b expected 0", frame_done); end
    rst       = 1'b0;
    n         = 0;
    m_pending = 16'h0;
    m_display = 16'h0;
    step(1'b0, 1'b0, 16'h0);
  endtask

  // Load 1234, then scan two full frames (first shows 0000, second shows 1234).
  task automatic test_scan();
    step(1'b1, 1'b1, 16'h1234);
    for (int k = 0; k < 2 * FRAME + 10; k++) step(1'b1, 1'b0, 16'($urandom));
  endtask

  // Mid-frame load waits for the boundary; a load on the frame_done cycle waits one more frame.
  task automatic test_back_to_back();
    bit found;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (n % FRAME == 15) break;
      step(1'b1, 1'b0, 16'h0);
    end
    step(1'b1, 1'b1, 16'hABCD);
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (n > 0 && n % FRAME == 0) begin found = 1'b1; break; end
      step(1'b1, 1'b0, 16'h0);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL boundary_wait got timeout expected frame_done"); end
    step(1'b1, 1'b1, 16'h5678);
    for (int k = 0; k < 2 * FRAME + 5; k++) step(1'b1, 1'b0, 16'($urandom));
  endtask

  // Drop enable during digit 2 DRIVE, then re-enable and restart from digit 0.
  task automatic test_enable_abort();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (n >= 1 && ((n - 1) / TICKS) % N == 2 && (n - 1) % TICKS >= 3) begin found = 1'b1; break; end
      step(1'b1, 1'b0, 16'h0);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_wait got timeout expected digit 2 drive"); end
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h9F0E);
    for (int k = 0; k < FRAME + 15; k++) step(1'b1, 1'b0, 16'h0);
  endtask

  // Reset asserted between edges mid-DRIVE must clear outputs immediately and drop pending data.
  task automatic test_async_reset();
    bit found;
    step(1'b1, 1'b1, 16'h8888);
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (n >= 2 && (n - 2) % TICKS >= BLK + 2 && ((n - 2) / TICKS) % N == 1) begin found = 1'b1; break; end
      step(1'b1, 1'b0, 16'h0);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL arst_wait got timeout expected drive"); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL arst_an got %b expected 1111", an); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL arst_seg got %h expected 7f", seg); end
    checks++;
    if (digit_idx !== 2'd0) begin errors++; $display("FAIL arst_idx got %0d expected 0", digit_idx); end
    @(negedge clk);
    rst       = 1'b0;
    n         = 0;
    m_pending = 16'h0;
    m_display = 16'h0;
    for (int k = 0; k < 2 * FRAME + 5; k++) step(1'b1, 1'b0, 16'h0);
  endtask

  task automatic test_leading_zero();
    step(1'b1, 1'b1, 16'h0040);
    for (int k = 0; k < 2 * FRAME; k++) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h0000);
    for (int k = 0; k < 2 * FRAME; k++) step(1'b1, 1'b0, 16'h0);
  endtask

  task automatic test_random();
    logic en;
    logic ld;
    for (int k = 0; k < 600; k++) begin
      en = ($urandom_range(0, 59) != 0);
      ld = ($urandom_range(0, 7) == 0);
      step(en, ld, 16'($urandom));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    glyph_tb[0]  = 7'b1000000; glyph_tb[1]  = 7'b1111001;
    glyph_tb[2]  = 7'b0100100; glyph_tb[3]  = 7'b0110000;
    glyph_tb[4]  = 7'b0011001; glyph_tb[5]  = 7'b0010010;
    glyph_tb[6]  = 7'b0000010; glyph_tb[7]  = 7'b1111000;
    glyph_tb[8]  = 7'b0000000; glyph_tb[9]  = 7'b0010000;
    glyph_tb[10] = 7'b0001000; glyph_tb[11] = 7'b0000011;
    glyph_tb[12] = 7'b1000110; glyph_tb[13] = 7'b0100001;
    glyph_tb[14] = 7'b0000110; glyph_tb[15] = 7'b0001110;

    test_reset();
    test_scan();
    test_back_to_back();
    test_enable_abort();
    test_async_reset();
    test_leading_zero();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
